// File: rtl/mulu_m2q2_ctrl.sv
// Sequencing controller for a combinational 2x2 multiplier core.
// Define MULU_SIGN_EN for two's-complement operands and a sign output s.
module mulu_m2q2_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] x_in,
  input  logic [1:0] y_in,
  output logic [1:0] op_x,
  output logic [1:0] op_y,
  input  logic [3:0] core_p,
  output logic [3:0] p,
  output logic       rdy,
  output logic       busy
`ifdef MULU_SIGN_EN
  ,
  output logic       s
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t     state_r;
  logic [3:0] cnt_r;
  logic [1:0] ld_x_s;
  logic [1:0] ld_y_s;

`ifdef MULU_SIGN_EN
  logic       ld_s_s;
  logic       sign_pend_r;
  logic       s_r;

  // Magnitude of a 2-bit two's-complement value (-2 maps to 2).
  function automatic logic [1:0] mag2(input logic [1:0] v);
    if (v[1]) begin
      mag2 = 2'(~v + 2'd1);
    end else begin
      mag2 = v;
    end
  endfunction

  // Operand conditioning: magnitudes to the core, sign kept aside.
  always_comb begin
    ld_x_s = mag2(x_in);
    ld_y_s = mag2(y_in);
    ld_s_s = (x_in[1] ^ y_in[1]) & (|ld_x_s) & (|ld_y_s);
  end

  assign s = s_r;
`else
  // Unsigned operands pass straight through to the core.
  always_comb begin
    ld_x_s = x_in;
    ld_y_s = y_in;
  end
`endif

  // Control FSM with registered operands, product and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      op_x        <= 2'd0;
      op_y        <= 2'd0;
      p           <= 4'd0;
      rdy         <= 1'b0;
      busy        <= 1'b0;
`ifdef MULU_SIGN_EN
      sign_pend_r <= 1'b0;
      s_r         <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // A load from DONE drops rdy on the same edge; p stays until replaced.
          if (start) begin
            op_x        <= ld_x_s;
            op_y        <= ld_y_s;
            cnt_r       <= 4'd0;
            rdy         <= 1'b0;
            busy        <= 1'b1;
            state_r     <= ST_WAIT;
`ifdef MULU_SIGN_EN
            sign_pend_r <= ld_s_s;
`endif
          end else begin
            state_r <= state_r;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == LAT_M1) begin
            p       <= core_p;
            rdy     <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_DONE;
`ifdef MULU_SIGN_EN
            s_r     <= sign_pend_r;
`endif
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rdy     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
